// File: rtl/decoder_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : decoder_scan_ctrl
// Description : Steps a 3:8 decoder select through the masked channels, holding
//               each for a programmable dwell; single-pass or wrapping scans.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_scan_ctrl #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               continuous,
    output logic [2:0]         sel,
    output logic               enable,
    output logic               busy,
    output logic               chan_tick,
    output logic               done
);

    localparam logic [DWELL_W-1:0] c_dwell_one  = DWELL_W'(1);
    localparam logic [DWELL_W-1:0] c_dwell_zero = '0;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [7:0]         r_mask, w_mask_nxt;
    logic [DWELL_W-1:0] r_dwell, w_dwell_nxt;
    logic [DWELL_W-1:0] r_cnt, w_cnt_nxt;
    logic               r_cont, w_cont_nxt;
    logic [2:0]         r_sel, w_sel_nxt;
    logic               r_enable, w_enable_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_tick, w_tick_nxt;
    logic               r_done, w_done_nxt;

    logic [DWELL_W-1:0] w_dwell_eff;
    logic [3:0]         w_next;

    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        lowest_bit = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) lowest_bit = 3'(i);
        end
    endfunction

    // Returns {found, index} of the lowest set bit strictly above idx.
    function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] idx);
        next_above = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (i > int'(idx))) next_above = {1'b1, 3'(i)};
        end
    endfunction

    assign w_dwell_eff = (dwell == c_dwell_zero) ? c_dwell_one : dwell;
    assign w_next      = next_above(r_mask, r_sel);

    always_comb begin
        w_state_nxt  = r_state;
        w_mask_nxt   = r_mask;
        w_dwell_nxt  = r_dwell;
        w_cont_nxt   = r_cont;
        w_cnt_nxt    = r_cnt;
        w_sel_nxt    = r_sel;
        w_enable_nxt = r_enable;
        w_busy_nxt   = r_busy;
        w_tick_nxt   = 1'b0;
        w_done_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start && (mask != 8'h00)) begin
                    w_state_nxt  = S_SCAN;
                    w_mask_nxt   = mask;
                    w_dwell_nxt  = w_dwell_eff;
                    w_cont_nxt   = continuous;
                    w_sel_nxt    = lowest_bit(mask);
                    w_cnt_nxt    = w_dwell_eff - c_dwell_one;
                    w_enable_nxt = 1'b1;
                    w_busy_nxt   = 1'b1;
                    w_tick_nxt   = 1'b1;
                end
            end
            S_SCAN: begin
                if (stop) begin
                    w_state_nxt  = S_IDLE;
                    w_sel_nxt    = 3'd0;
                    w_enable_nxt = 1'b0;
                    w_busy_nxt   = 1'b0;
                end else if (r_cnt != c_dwell_zero) begin
                    w_cnt_nxt = r_cnt - c_dwell_one;
                end else if (w_next[3]) begin
                    w_sel_nxt  = w_next[2:0];
                    w_cnt_nxt  = r_dwell - c_dwell_one;
                    w_tick_nxt = 1'b1;
                end else if (r_cont) begin
                    // A single-bit mask re-enters the same channel here.
                    w_sel_nxt  = lowest_bit(r_mask);
                    w_cnt_nxt  = r_dwell - c_dwell_one;
                    w_tick_nxt = 1'b1;
                end else begin
                    w_state_nxt  = S_IDLE;
                    w_sel_nxt    = 3'd0;
                    w_enable_nxt = 1'b0;
                    w_busy_nxt   = 1'b0;
                    w_done_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_sel_nxt    = 3'd0;
                w_enable_nxt = 1'b0;
                w_busy_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_mask   <= 8'h00;
            r_dwell  <= c_dwell_zero;
            r_cont   <= 1'b0;
            r_cnt    <= c_dwell_zero;
            r_sel    <= 3'd0;
            r_enable <= 1'b0;
            r_busy   <= 1'b0;
            r_tick   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mask   <= w_mask_nxt;
            r_dwell  <= w_dwell_nxt;
            r_cont   <= w_cont_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sel    <= w_sel_nxt;
            r_enable <= w_enable_nxt;
            r_busy   <= w_busy_nxt;
            r_tick   <= w_tick_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign sel       = r_sel;
    assign enable    = r_enable;
    assign busy      = r_busy;
    assign chan_tick = r_tick;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_decoder_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_scan_ctrl
// Description : Scoreboard bench for decoder_scan_ctrl using directed scans.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_scan_ctrl;

    typedef struct packed {
        logic [2:0] sel;
        logic       enable;
        logic       busy;
        logic       tick;
        logic       done;
    } obs_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [7:0] mask;
    logic [7:0] dwell;
    logic       continuous;
    logic [2:0] sel;
    logic       enable;
    logic       busy;
    logic       chan_tick;
    logic       done;

    obs_t exp_q[$];
    int   checks;
    int   errors;

    decoder_scan_ctrl #(.DWELL_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .mask       (mask),
        .dwell      (dwell),
        .continuous (continuous),
        .sel        (sel),
        .enable     (enable),
        .busy       (busy),
        .chan_tick  (chan_tick),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic push_ch(input logic [2:0] s, input logic t);
        exp_q.push_back('{sel: s, enable: 1'b1, busy: 1'b1, tick: t, done: 1'b0});
    endtask

    task automatic push_channel(input logic [2:0] s, input int d);
        push_ch(s, 1'b1);
        for (int k = 1; k < d; k++) push_ch(s, 1'b0);
    endtask

    task automatic push_done();
        exp_q.push_back('{sel: 3'd0, enable: 1'b0, busy: 1'b0, tick: 1'b0, done: 1'b1});
    endtask

    task automatic issue_start(input logic [7:0] m, input logic [7:0] d, input logic c);
        @(posedge clk); #1;
        mask = m; dwell = d; continuous = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_idle(input string name);
        chk(name, {27'd0, sel, enable, busy, chan_tick, done}, 32'd0);
    endtask

    // Monitor: every active output cycle must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("enable_eq_busy", {31'd0, enable}, {31'd0, busy});
            if (enable || busy || chan_tick || done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output got=%0h expected=none",
                             {sel, enable, busy, chan_tick, done});
                end else begin
                    obs_t e;
                    e = exp_q.pop_front();
                    chk("scan_output", {25'd0, sel, enable, busy, chan_tick, done}, {25'd0, e});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        mask = 8'h00; dwell = 8'd0; continuous = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset_state");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle("post_reset_quiet");

        // 1: A5, dwell 2, single pass
        push_ch(3'd0, 1'b1); push_ch(3'd0, 1'b0);
        push_ch(3'd2, 1'b1); push_ch(3'd2, 1'b0);
        push_ch(3'd5, 1'b1); push_ch(3'd5, 1'b0);
        push_ch(3'd7, 1'b1); push_ch(3'd7, 1'b0);
        push_done();
        issue_start(8'hA5, 8'd2, 1'b0);
        wait_drain("t1_drain");
        check_idle("t1_idle");

        // 2: empty mask ignored
        @(posedge clk); #1;
        mask = 8'h00; dwell = 8'd3; start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("t2_mask_zero");

        // 3: FF, dwell 0 treated as 1
        for (int c = 0; c < 8; c++) push_ch(3'(c), 1'b1);
        push_done();
        issue_start(8'hFF, 8'd0, 1'b0);
        wait_drain("t3_drain");

        // 4: 81 continuous, stop after six channel cycles
        push_ch(3'd0, 1'b1); push_ch(3'd7, 1'b1);
        push_ch(3'd0, 1'b1); push_ch(3'd7, 1'b1);
        push_ch(3'd0, 1'b1); push_ch(3'd7, 1'b1);
        issue_start(8'h81, 8'd1, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        check_idle("t4_after_stop");
        wait_drain("t4_drain");
        continuous = 1'b0;

        // 5: single channel; mid-scan input changes must not matter
        push_channel(3'd4, 3);
        push_done();
        issue_start(8'h10, 8'd3, 1'b0);
        mask = 8'h01; dwell = 8'd9;
        wait_drain("t5_drain");

        // 6: async reset mid-scan, then a fresh scan from channel 0
        push_ch(3'd0, 1'b1); push_ch(3'd0, 1'b0);
        issue_start(8'hFF, 8'd4, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_drop", {30'd0, enable, busy}, 32'd0);
        chk("t6_pending", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 8; c++) push_channel(3'(c), 4);
        push_done();
        issue_start(8'hFF, 8'd4, 1'b0);
        wait_drain("t6_drain");
        check_idle("t6_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
